// File: rtl/ysyx_22040125_imem_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22040125_imem_pkg
// Shared types and constants for the instruction-RAM arbiter slice:
//   - state_e : sequencer states (IDLE, WAIT, RESP)
//   - gnt_t   : grant id, with GNT_IF / GNT_LD constants
//   - ADDR_W, DATA_W, PC_W : default widths for the arbiter parameters
// ----------------------------------------------------------------------------
package ysyx_22040125_imem_pkg;

    localparam int ADDR_W = 16;  // RAM word address (65536 x 32-bit words)
    localparam int DATA_W = 32;  // instruction / data word
    localparam int PC_W   = 64;  // PC tag carried with each fetch

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // may accept one request
        WAIT = 2'd1,  // RAM read data returns this cycle
        RESP = 2'd2   // response held until accepted
    } state_e;

    typedef logic gnt_t;
    localparam gnt_t GNT_IF = 1'b0;
    localparam gnt_t GNT_LD = 1'b1;

endpackage

// File: rtl/ysyx_22040125_rr_pick.sv
// ----------------------------------------------------------------------------
// ysyx_22040125_rr_pick
// Two-way grant selector between instruction fetch (IF) and loader (LD).
//
// Build option: YSYX_22040125_IMEM_RR_EN
//   defined   : two-way round-robin; on a tie the requester that did not win
//               the last accepted grant is chosen. The pointer moves only on
//               acceptance and resets to LD-last, so IF wins the first tie.
//   undefined : fixed priority, LD over IF; no pointer register exists.
//
// Ports
//   clk, rst  : clock, synchronous active-low reset
//   if_valid  : IF request pending
//   ld_valid  : LD request pending
//   accept    : the current grant is being accepted this cycle
//   gnt_valid : at least one requester is pending
//   gnt_id    : selected requester (GNT_IF / GNT_LD), meaningful with gnt_valid
// ----------------------------------------------------------------------------
module ysyx_22040125_rr_pick
    import ysyx_22040125_imem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic if_valid,
    input  logic ld_valid,
    input  logic accept,
    output logic gnt_valid,
    output gnt_t gnt_id
);

    assign gnt_valid = if_valid | ld_valid;

`ifdef YSYX_22040125_IMEM_RR_EN
    gnt_t last_gnt;

    // NOTE: every always_comb output gets a value on every path (here via the
    // full if/else) so no latch is inferred.
    always_comb begin
        if (if_valid && ld_valid) begin
            gnt_id = (last_gnt == GNT_LD) ? GNT_IF : GNT_LD;
        end else begin
            gnt_id = ld_valid ? GNT_LD : GNT_IF;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together at the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_gnt <= GNT_LD;
        end else if (accept) begin
            last_gnt <= gnt_id;
        end
    end
`else
    assign gnt_id = ld_valid ? GNT_LD : GNT_IF;

    // Clock, reset and accept only feed the round-robin pointer.
    logic unused_rr;
    assign unused_rr = ^{clk, rst, accept};
`endif

endmodule

// File: rtl/ysyx_22040125_imem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_22040125_imem_arbiter
// Shares the single synchronous-read instruction RAM port between the fetch
// stage (IF, read-only) and the program loader (LD, read/write). One access
// is in flight at a time: IDLE accepts and strobes the RAM, WAIT captures the
// read data, RESP holds the response until its owner accepts it. Peak rate is
// one access every three cycles.
//
// Build option: YSYX_22040125_IMEM_RR_EN selects round-robin arbitration;
// otherwise LD has fixed priority over IF (see ysyx_22040125_rr_pick).
//
// Ports
//   clk, rst                      : clock, synchronous active-low reset
//   if_req_valid/ready, addr, pc  : fetch request; pc is echoed back
//   if_rsp_valid/ready, inst, pc  : fetch response
//   ld_req_valid/ready, we, addr, wdata : loader request
//   ld_rsp_valid/ready, rdata     : loader response (rdata = 0 for writes)
//   mem_en, mem_we, mem_addr, mem_wdata : RAM command, driven in the accept cycle
//   mem_rdata                     : RAM read data, valid the cycle after mem_en
// ----------------------------------------------------------------------------
module ysyx_22040125_imem_arbiter #(
    parameter int ADDR_W = ysyx_22040125_imem_pkg::ADDR_W,
    parameter int DATA_W = ysyx_22040125_imem_pkg::DATA_W,
    parameter int PC_W   = ysyx_22040125_imem_pkg::PC_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    input  logic [PC_W-1:0]   if_req_pc,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [DATA_W-1:0] if_rsp_inst,
    output logic [PC_W-1:0]   if_rsp_pc,

    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic              ld_req_we,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic [DATA_W-1:0] ld_req_wdata,
    output logic              ld_rsp_valid,
    input  logic              ld_rsp_ready,
    output logic [DATA_W-1:0] ld_rsp_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import ysyx_22040125_imem_pkg::*;

    state_e            state;
    gnt_t              owner;     // requester that owns the in-flight access
    logic              owner_wr;  // in-flight access is an LD write
    logic [PC_W-1:0]   pc_tag;

    logic              gnt_valid;
    gnt_t              gnt_id;
    logic              idle;
    logic              accept;
    logic              rsp_fire;

    ysyx_22040125_rr_pick u_pick (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_req_valid),
        .ld_valid  (ld_req_valid),
        .accept    (accept),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Nothing is accepted while reset is asserted, so no RAM write can be
    // strobed and both req_ready outputs show their reset value.
    assign idle         = (state == IDLE) && rst;
    assign accept       = idle && gnt_valid;
    assign if_req_ready = accept && (gnt_id == GNT_IF);
    assign ld_req_ready = accept && (gnt_id == GNT_LD);

    // RAM command comes straight from the granted requester in the accept
    // cycle; outside an access the command lines rest at zero.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (accept) begin
            mem_en = 1'b1;
            if (gnt_id == GNT_LD) begin
                mem_we    = ld_req_we;
                mem_addr  = ld_req_addr;
                mem_wdata = ld_req_wdata;
            end else begin
                mem_addr  = if_req_addr;
            end
        end
    end

    assign rsp_fire = (owner == GNT_LD) ? (ld_rsp_valid && ld_rsp_ready)
                                        : (if_rsp_valid && if_rsp_ready);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            owner        <= GNT_IF;
            owner_wr     <= 1'b0;
            pc_tag       <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_inst  <= '0;
            if_rsp_pc    <= '0;
            ld_rsp_valid <= 1'b0;
            ld_rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner    <= gnt_id;
                        owner_wr <= (gnt_id == GNT_LD) && ld_req_we;
                        pc_tag   <= if_req_pc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (owner == GNT_LD) begin
                        // Writes answer with zero, not whatever the RAM drove.
                        ld_rsp_rdata <= owner_wr ? '0 : mem_rdata;
                        ld_rsp_valid <= 1'b1;
                    end else begin
                        if_rsp_inst  <= mem_rdata;
                        if_rsp_pc    <= pc_tag;
                        if_rsp_valid <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_fire) begin
                        if_rsp_valid <= 1'b0;
                        ld_rsp_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040125_imem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22040125_imem_arbiter
// Self-checking bench: a behavioural RAM, a transaction-level reference model
// checked every cycle, a table of directed transactions, hand-written corner
// sequences (arbitration ties, response stall, reset mid-access) and a
// randomized phase.
// ----------------------------------------------------------------------------
module tb_ysyx_22040125_imem_arbiter;

`ifdef YSYX_22040125_IMEM_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        if_req_valid, if_req_ready;
    logic [15:0] if_req_addr;
    logic [63:0] if_req_pc;
    logic        if_rsp_valid, if_rsp_ready;
    logic [31:0] if_rsp_inst;
    logic [63:0] if_rsp_pc;
    logic        ld_req_valid, ld_req_ready, ld_req_we;
    logic [15:0] ld_req_addr;
    logic [31:0] ld_req_wdata;
    logic        ld_rsp_valid, ld_rsp_ready;
    logic [31:0] ld_rsp_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    ysyx_22040125_imem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_req_pc    (if_req_pc),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_ready (if_rsp_ready),
        .if_rsp_inst  (if_rsp_inst),
        .if_rsp_pc    (if_rsp_pc),
        .ld_req_valid (ld_req_valid),
        .ld_req_ready (ld_req_ready),
        .ld_req_we    (ld_req_we),
        .ld_req_addr  (ld_req_addr),
        .ld_req_wdata (ld_req_wdata),
        .ld_rsp_valid (ld_rsp_valid),
        .ld_rsp_ready (ld_rsp_ready),
        .ld_rsp_rdata (ld_rsp_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port synchronous-read RAM.
    logic [31:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // Reference model: one outstanding transaction, its age in cycles since
    // acceptance, and the response it must produce.
    logic [31:0] ref_mem [0:65535];
    bit          m_busy;
    bit          m_owner_ld;
    bit          m_last_ld;
    int          m_age;
    logic [31:0] m_data;
    logic [63:0] m_pc;

    bit          acc_seen;
    bit          rsp_seen;
    logic [31:0] rsp_data;
    bit          grant_log[$];

    int n_checks;
    int n_pass;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock cycle: inputs are already set; sample at negedge, compare with
    // the model, then advance the model at the posedge.
    task automatic cycle();
        bit          in_rst, pick_ld, e_if_rdy, e_ld_rdy, acc, e_if_v, e_ld_v, fire;
        bit          a_we;
        logic [15:0] a_addr;
        logic [31:0] a_wdata;
        logic [63:0] a_pc;
        @(negedge clk);
        in_rst  = !rst;
        pick_ld = ld_req_valid && (!if_req_valid || (RR ? !m_last_ld : 1'b1));
        if (in_rst || m_busy) begin
            e_if_rdy = 1'b0;
            e_ld_rdy = 1'b0;
        end else begin
            e_ld_rdy = pick_ld;
            e_if_rdy = if_req_valid && !pick_ld;
        end
        check("if_req_ready", if_req_ready, e_if_rdy);
        check("ld_req_ready", ld_req_ready, e_ld_rdy);
        acc = e_if_rdy || e_ld_rdy;
        check("mem_en", mem_en, acc);
        a_we    = e_ld_rdy && ld_req_we;
        a_addr  = e_ld_rdy ? ld_req_addr : if_req_addr;
        a_wdata = ld_req_wdata;
        a_pc    = if_req_pc;
        if (acc) begin
            check("mem_we", mem_we, a_we);
            check("mem_addr", mem_addr, a_addr);
            check("mem_wdata", mem_wdata, e_ld_rdy ? ld_req_wdata : 32'h0);
        end else begin
            check("mem_we_idle", mem_we, 1'b0);
        end
        e_if_v = m_busy && !m_owner_ld && (m_age >= 2);
        e_ld_v = m_busy &&  m_owner_ld && (m_age >= 2);
        check("if_rsp_valid", if_rsp_valid, e_if_v);
        check("ld_rsp_valid", ld_rsp_valid, e_ld_v);
        if (e_if_v) begin
            check("if_rsp_inst", if_rsp_inst, m_data);
            check("if_rsp_pc", if_rsp_pc, m_pc);
        end
        if (e_ld_v) check("ld_rsp_rdata", ld_rsp_rdata, m_data);
        fire = (e_if_v && if_rsp_ready) || (e_ld_v && ld_rsp_ready);
        if (fire) begin
            rsp_seen = 1'b1;
            rsp_data = e_ld_v ? ld_rsp_rdata : if_rsp_inst;
        end
        acc_seen = acc;
        if (acc) grant_log.push_back(e_ld_rdy);
        @(posedge clk);
        if (in_rst) begin
            m_busy    = 1'b0;
            m_age     = 0;
            m_last_ld = 1'b1;
        end else if (acc) begin
            m_busy     = 1'b1;
            m_age      = 1;
            m_owner_ld = e_ld_rdy;
            m_last_ld  = e_ld_rdy;
            m_pc       = a_pc;
            if (a_we) begin
                m_data          = 32'h0;
                ref_mem[a_addr] = a_wdata;
            end else begin
                m_data = ref_mem[a_addr];
            end
        end else if (m_busy) begin
            if (fire) m_busy = 1'b0;
            else if (m_age < 2) m_age++;
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_req_ready"}, if_req_ready, 1'b0);
        check({tag, "_ld_req_ready"}, ld_req_ready, 1'b0);
        check({tag, "_rsp_valids"}, {if_rsp_valid, ld_rsp_valid}, 2'b00);
        check({tag, "_if_rsp_inst"}, if_rsp_inst, 32'h0);
        check({tag, "_if_rsp_pc"}, if_rsp_pc, 64'h0);
        check({tag, "_ld_rsp_rdata"}, ld_rsp_rdata, 32'h0);
        check({tag, "_mem_cmd"}, {mem_en, mem_we, mem_addr, mem_wdata}, 50'h0);
    endtask

    task automatic idle_inputs();
        if_req_valid = 1'b0;
        ld_req_valid = 1'b0;
        ld_req_we    = 1'b0;
        if_rsp_ready = 1'b1;
        ld_rsp_ready = 1'b1;
    endtask

    task automatic wait_accept(input string name);
        int k = 0;
        do begin
            cycle();
            k++;
        end while (!acc_seen && k < 20);
        check({name, "_accepted"}, acc_seen, 1'b1);
    endtask

    task automatic wait_rsp(input string name, output int lat);
        lat = 0;
        rsp_seen = 1'b0;
        while (!rsp_seen && lat < 20) begin
            cycle();
            lat++;
        end
        check({name, "_responded"}, rsp_seen, 1'b1);
    endtask

    typedef struct {
        string       name;
        bit          is_ld;
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [63:0] pc;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat;
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = (i * 32'h0100_0193) ^ 32'h5A5A_0000;
            ref_mem[i] = ram[i];
        end
        ram[16]     = 32'h0000_0013;
        ref_mem[16] = 32'h0000_0013;
        mem_rdata   = 32'h0;
        m_busy = 1'b0; m_age = 0; m_last_ld = 1'b1; m_owner_ld = 1'b0;
        m_data = '0; m_pc = '0;

        vecs[0] = '{"if_rd_0010",  1'b0, 1'b0, 16'h0010, 32'h0,         64'h8000_0040, 32'h0000_0013};
        vecs[1] = '{"ld_wr_0020",  1'b1, 1'b1, 16'h0020, 32'hDEAD_BEEF, 64'h0,         32'h0000_0000};
        vecs[2] = '{"if_rd_0020",  1'b0, 1'b0, 16'h0020, 32'h0,         64'h8000_0044, 32'hDEAD_BEEF};
        vecs[3] = '{"ld_rd_0020",  1'b1, 1'b0, 16'h0020, 32'h1111_2222, 64'h0,         32'hDEAD_BEEF};
        vecs[4] = '{"ld_wr_ffff",  1'b1, 1'b1, 16'hFFFF, 32'h1234_5678, 64'h0,         32'h0000_0000};
        vecs[5] = '{"if_rd_ffff",  1'b0, 1'b0, 16'hFFFF, 32'h0,         64'hFFFF_FFFF_FFFF_FFFC, 32'h1234_5678};
        vecs[6] = '{"ld_rd_0000",  1'b1, 1'b0, 16'h0000, 32'h0,         64'h0,         32'h5A5A_0000};

        // Reset with both requesters pending: nothing may be accepted.
        rst = 1'b0;
        idle_inputs();
        if_req_valid = 1'b1; if_req_addr = 16'h0010; if_req_pc = 64'h1;
        ld_req_valid = 1'b1; ld_req_addr = 16'h0020; ld_req_wdata = 32'h5;
        cycle();
        cycle();
        check_reset_outputs("reset");
        idle_inputs();
        rst = 1'b1;
        cycle();

        // Directed transactions, one requester at a time, ready held high.
        foreach (vecs[i]) begin
            if (vecs[i].is_ld) begin
                ld_req_valid = 1'b1;
                ld_req_we    = vecs[i].we;
                ld_req_addr  = vecs[i].addr;
                ld_req_wdata = vecs[i].wdata;
            end else begin
                if_req_valid = 1'b1;
                if_req_addr  = vecs[i].addr;
                if_req_pc    = vecs[i].pc;
            end
            wait_accept(vecs[i].name);
            idle_inputs();
            wait_rsp(vecs[i].name, lat);
            check({vecs[i].name, "_data"}, rsp_data, vecs[i].exp);
            check({vecs[i].name, "_latency"}, lat, 2);
        end

        // Both requesters valid every cycle, starting from reset.
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        grant_log.delete();
        if_req_valid = 1'b1; if_req_addr = 16'h0010; if_req_pc = 64'h8000_0100;
        ld_req_valid = 1'b1; ld_req_we = 1'b0; ld_req_addr = 16'h0020;
        for (int k = 0; k < 40 && grant_log.size() < 4; k++) cycle();
        check("tie_grant_count", grant_log.size(), 4);
        for (int g = 0; g < 4 && g < grant_log.size(); g++) begin
            check($sformatf("tie_grant_%0d_is_ld", g), grant_log[g], RR ? ((g % 2) == 1) : 1'b1);
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) cycle();

        // Fetch response stalled for 5 cycles while LD waits.
        if_req_valid = 1'b1; if_req_addr = 16'h0010; if_req_pc = 64'h8000_0200;
        if_rsp_ready = 1'b0;
        wait_accept("stall_if");
        if_req_valid = 1'b0;
        ld_req_valid = 1'b1; ld_req_we = 1'b0; ld_req_addr = 16'h0030;
        cycle();
        for (int k = 0; k < 5; k++) begin
            cycle();
            check($sformatf("stall_no_accept_%0d", k), acc_seen, 1'b0);
            check($sformatf("stall_inst_%0d", k), if_rsp_inst, 32'h0000_0013);
        end
        if_rsp_ready = 1'b1;
        rsp_seen = 1'b0;
        cycle();
        check("stall_handshake", rsp_seen, 1'b1);
        cycle();
        check("stall_next_accept", acc_seen, 1'b1);
        idle_inputs();
        wait_rsp("stall_ld", lat);

        // Reset asserted while a fetch is in WAIT: the fetch is abandoned.
        if_req_valid = 1'b1; if_req_addr = 16'h0011; if_req_pc = 64'h8000_0300;
        wait_accept("rst_wait");
        rst = 1'b0;
        ld_req_valid = 1'b1; ld_req_addr = 16'h0022;
        cycle();
        check_reset_outputs("rst_wait");
        idle_inputs();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check($sformatf("abandoned_%0d", k), {if_rsp_valid, ld_rsp_valid}, 2'b00);
        end

        // Randomized traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            if_req_valid = ($urandom_range(0, 99) < 50);
            if_req_addr  = 16'h0020 + 16'($urandom_range(0, 7));
            if_req_pc    = {$urandom, $urandom};
            ld_req_valid = ($urandom_range(0, 99) < 40);
            ld_req_we    = $urandom_range(0, 1);
            ld_req_addr  = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'h0020 + 16'($urandom_range(0, 7));
            ld_req_wdata = $urandom;
            if_rsp_ready = ($urandom_range(0, 99) < 70);
            ld_rsp_ready = ($urandom_range(0, 99) < 70);
            cycle();
        end
        idle_inputs();
        for (int k = 0; k < 5; k++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22040125_imem_arbiter.md
# ysyx_22040125_imem_arbiter

Arbiter and sequencer for the single-port instruction RAM. It shares one synchronous-read RAM port between two requesters: instruction fetch (IF, read-only) and the program loader/debug port (LD, read/write). It serialises accesses, drives the RAM enable/address/write lines, and returns each response on a valid/ready channel. It sits between the IF stage and the instruction RAM, replacing direct PC-to-RAM addressing.

## Interface
- ADDR_W, 16, RAM word-address width (65536 x 32-bit words)
- DATA_W, 32, instruction/data word width
- PC_W, 64, width of the PC tag carried with each fetch

- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-low
- if_req_valid / if_req_ready  in / out  1  fetch request handshake
- if_req_addr  in  ADDR_W  fetch word address
- if_req_pc  in  PC_W  PC tag, echoed on the response
- if_rsp_valid / if_rsp_ready  out / in  1  fetch response handshake
- if_rsp_inst  out  DATA_W  fetched instruction
- if_rsp_pc  out  PC_W  echoed PC tag
- ld_req_valid / ld_req_ready  in / out  1  loader request handshake
- ld_req_we  in  1  1 = write, 0 = read
- ld_req_addr  in  ADDR_W  loader word address
- ld_req_wdata  in  DATA_W  write data
- ld_rsp_valid / ld_rsp_ready  out / in  1  loader response; one response per request, including writes
- ld_rsp_rdata  out  DATA_W  read data; 0 for writes
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en

## Operation
- States:
  - IDLE: may accept one request.
  - WAIT: RAM data returns; the block latches it into the response register.
  - RESP: holds the response until it is accepted.
- Only one transaction is in flight at a time.
- IDLE:
  - The arbiter picks a grant among valid requesters.
  - The granted req_ready is high (combinational on the valid inputs); the other req_ready is 0.
  - When a request is accepted, mem_en=1 and mem_we/mem_addr/mem_wdata come from the granted requester in the same cycle.
  - The block stores the grant id, the PC tag and the write flag.
  - Transition to WAIT.
  - With no valid request, stay in IDLE with mem_en=0.
- WAIT:
  - Latch mem_rdata into the response register; for LD writes, load 0 instead.
  - Assert the owner's rsp_valid from the next cycle.
  - Transition to RESP.
- RESP:
  - rsp_valid and response data stay stable until rsp_ready.
  - On rsp_ready, clear rsp_valid and return to IDLE.
  - Both req_ready outputs are 0 in WAIT and RESP.
- Fixed priority (macro undefined): LD wins over IF whenever both are valid.
- Write then read of the same address: the read observes the written data, because accesses are strictly serialised.
- Address: used verbatim; no wrap or range checking.

## Timing
- Request accepted in cycle N; rsp_valid is high from cycle N+2.
- If rsp_ready is held high, the response handshakes in cycle N+2 and the next request can be accepted in N+3. Peak throughput is 1 access per 3 cycles.
- Reset values: state IDLE; if_rsp_valid=0, ld_rsp_valid=0; if_rsp_inst=0, if_rsp_pc=0, ld_rsp_rdata=0; both req_ready=0; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; round-robin pointer = LD-last, so IF wins the first tie.
- Reset asserted mid-transaction: the transaction is discarded and no response is issued. A RAM write already strobed is not undone.
- A requester may drop req_valid before acceptance; there is no penalty.

## Configuration
- YSYX_22040125_IMEM_RR_EN defined:
  - Two-way round-robin.
  - On a tie, grant the requester that did not win the last accepted grant.
  - The pointer updates only on acceptance.
- Undefined: fixed LD-over-IF priority as described under Operation; no pointer register exists.

## Structure
- Package ysyx_22040125_imem_pkg:
  - state enum (IDLE, WAIT, RESP)
  - grant id constants (GNT_IF, GNT_LD)
  - ADDR_W, DATA_W, PC_W defaults
- Sub-module ysyx_22040125_rr_pick:
  - two-way grant selector
  - contains the round-robin pointer under the macro; fixed priority otherwise
- The FSM and response registers live in the top module.

## Test plan
- Reset, then IF read of addr 0x0010 (RAM holds 0x00000013), pc 0x80000040 -> accepted in N, if_rsp_valid in N+2 with inst 0x00000013, pc 0x80000040.
- LD write of 0xDEADBEEF to 0x0020, then IF read of 0x0020 -> ld_rsp_rdata=0; IF receives 0xDEADBEEF.
- Both valid every cycle, macro undefined -> LD granted every time; IF is stalled while LD stays valid.
- Both valid every cycle, macro defined -> grants alternate IF, LD, IF, LD, starting with IF.
- if_rsp_ready held low for 5 cycles -> response stable, no new acceptance; ready raised -> handshake, and the next accept follows in the next cycle.
- rst low in the WAIT state -> all outputs return to reset values next cycle; no rsp_valid ever appears for the abandoned request.
